sc_reg_lfsr_gen: RTL and testbench

Parametrised pseudo-random word generator built on a Fibonacci LFSR with programmable width, tap mask and shifts-per-word. It supports seed loading, zero-seed lock-up protection, free-run and on-demand modes, and a valid/ready output handshake. It sits in the register/shifter family and feeds game and test logic that consumes random values under back-pressure.

---
 rtl/sc_reg_lfsr_pkg.sv | 20 ++
 rtl/sc_lfsr_step.sv | 26 ++
 rtl/sc_reg_lfsr_gen.sv | 109 ++++++++++
 tb/tb_sc_reg_lfsr_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_reg_lfsr_pkg.sv
// Shared constants for the LFSR word generator: FSM state codes, mode codes
// and default maximal-length tap masks for common widths.
package sc_reg_lfsr_pkg;

    // FSM state codes
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    // Mode codes driven on the mode bus (2'b11 behaves like HOLD)
    localparam logic [1:0] HOLD     = 2'b00;
    localparam logic [1:0] FREERUN  = 2'b01;
    localparam logic [1:0] ONDEMAND = 2'b10;

    // Maximal-length Fibonacci tap masks
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

endpackage

// File: rtl/sc_lfsr_step.sv
// One combinational Fibonacci LFSR step: shift left, feedback = parity of
// the tapped bits. Kept separate so several copies can be chained to
// unroll multiple steps per clock later.
module sc_lfsr_step
    import sc_reg_lfsr_pkg::*;
#(
    parameter int                   DATAWIDTH = 8,
    parameter logic [DATAWIDTH-1:0] TAPS      = TAPS_W8
) (
    input  logic [DATAWIDTH-1:0] i_state,
    output logic [DATAWIDTH-1:0] o_next
);

    logic [DATAWIDTH-1:0] w_tapped;

    genvar gi;
    generate
        for (gi = 0; gi < DATAWIDTH; gi++) begin : g_tap
            // Only bits selected by the mask contribute to the feedback
            assign w_tapped[gi] = TAPS[gi] & i_state[gi];
        end
    endgenerate

    assign o_next = {i_state[DATAWIDTH-2:0], ^w_tapped};

endmodule

// File: rtl/sc_reg_lfsr_gen.sv
// Pseudo-random word generator: an LFSR advanced STEPS_PER_WORD times per
// word, presented on a valid/ready handshake, with seed loading, zero-seed
// substitution and free-run / on-demand operation.
module sc_reg_lfsr_gen
    import sc_reg_lfsr_pkg::*;
#(
    parameter int                   DATAWIDTH      = 8,
    parameter logic [DATAWIDTH-1:0] TAPS           = TAPS_W8,
    parameter int unsigned          RESET_SEED     = 1,
    parameter int                   STEPS_PER_WORD = 1
) (
    input  logic                 SC_RegLFSR_CLOCK_50,
    input  logic                 SC_RegLFSR_RESET_InLow,
    input  logic [DATAWIDTH-1:0] SC_RegLFSR_seed_InBUS,
    input  logic                 SC_RegLFSR_load_In,
    input  logic [1:0]           SC_RegLFSR_mode_InBUS,
    input  logic                 SC_RegLFSR_req_In,
    input  logic                 SC_RegLFSR_ready_In,
    output logic [DATAWIDTH-1:0] SC_RegLFSR_data_OutBUS,
    output logic                 SC_RegLFSR_valid_Out,
    output logic                 SC_RegLFSR_wrap_Out
);

    localparam int                   CW      = $clog2(STEPS_PER_WORD + 1);
    localparam logic [CW-1:0]        STEPS_C = CW'(STEPS_PER_WORD);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [DATAWIDTH-1:0] SEED_C  = DATAWIDTH'(RESET_SEED);
    // Where a freshly started word goes: straight to PRESENT for single-step words
    localparam logic [1:0]           START_ST = (STEPS_PER_WORD == 1) ? PRESENT : SHIFT;

    logic [DATAWIDTH-1:0] r_lfsr;
    logic [DATAWIDTH-1:0] r_seed_ref;
    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;

    logic [DATAWIDTH-1:0] w_step;
    logic [DATAWIDTH-1:0] w_load_val;
    logic                 w_go;
    logic                 w_valid;

    sc_lfsr_step #(
        .DATAWIDTH (DATAWIDTH),
        .TAPS      (TAPS)
    ) u_step (
        .i_state (r_lfsr),
        .o_next  (w_step)
    );

    // A zero seed would lock the LFSR at zero, so substitute the reset seed
    assign w_load_val = (SC_RegLFSR_seed_InBUS == '0) ? SEED_C : SC_RegLFSR_seed_InBUS;

    // Current mode asks for a new word (HOLD and the unused code never do)
    assign w_go = (SC_RegLFSR_mode_InBUS == FREERUN) ||
                  ((SC_RegLFSR_mode_InBUS == ONDEMAND) && SC_RegLFSR_req_In);

    // Sequencer: reset, then load, then word FSM
    always_ff @(posedge SC_RegLFSR_CLOCK_50) begin
        if (!SC_RegLFSR_RESET_InLow) begin
            r_lfsr     <= SEED_C;
            r_seed_ref <= SEED_C;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else if (SC_RegLFSR_load_In) begin
            r_lfsr     <= w_load_val;
            r_seed_ref <= w_load_val;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_lfsr  <= w_step;
                        r_cnt   <= CNT_ONE;
                        r_state <= START_ST;
                    end
                end
                SHIFT: begin
                    // Mode and req are ignored until the word completes
                    r_lfsr <= w_step;
                    r_cnt  <= r_cnt + 1'b1;
                    if ((r_cnt + 1'b1) == STEPS_C) begin
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (SC_RegLFSR_ready_In) begin
                        if (w_go) begin
                            r_lfsr  <= w_step;
                            r_cnt   <= CNT_ONE;
                            r_state <= START_ST;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_valid                = (r_state == PRESENT);
    assign SC_RegLFSR_valid_Out   = w_valid;
    assign SC_RegLFSR_data_OutBUS = r_lfsr;
    assign SC_RegLFSR_wrap_Out    = w_valid && (r_lfsr == r_seed_ref);

endmodule

// File: tb/tb_sc_reg_lfsr_gen.sv
// Self-checking bench for sc_reg_lfsr_gen: one single-step and one
// three-step instance share stimulus; a word-level LFSR model provides
// every expected value.
module tb_sc_reg_lfsr_gen;

    localparam logic [7:0] TAPS = 8'hB8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seed;
    logic       load;
    logic [1:0] mode;
    logic       req;
    logic       ready;

    logic [7:0] data1, data3;
    logic       valid1, valid3, wrap1, wrap3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sc_reg_lfsr_gen #(
        .DATAWIDTH(8), .TAPS(TAPS), .RESET_SEED(1), .STEPS_PER_WORD(1)
    ) dut1 (
        .SC_RegLFSR_CLOCK_50    (clk),
        .SC_RegLFSR_RESET_InLow (rst_n),
        .SC_RegLFSR_seed_InBUS  (seed),
        .SC_RegLFSR_load_In     (load),
        .SC_RegLFSR_mode_InBUS  (mode),
        .SC_RegLFSR_req_In      (req),
        .SC_RegLFSR_ready_In    (ready),
        .SC_RegLFSR_data_OutBUS (data1),
        .SC_RegLFSR_valid_Out   (valid1),
        .SC_RegLFSR_wrap_Out    (wrap1)
    );

    sc_reg_lfsr_gen #(
        .DATAWIDTH(8), .TAPS(TAPS), .RESET_SEED(1), .STEPS_PER_WORD(3)
    ) dut3 (
        .SC_RegLFSR_CLOCK_50    (clk),
        .SC_RegLFSR_RESET_InLow (rst_n),
        .SC_RegLFSR_seed_InBUS  (seed),
        .SC_RegLFSR_load_In     (load),
        .SC_RegLFSR_mode_InBUS  (mode),
        .SC_RegLFSR_req_In      (req),
        .SC_RegLFSR_ready_In    (ready),
        .SC_RegLFSR_data_OutBUS (data3),
        .SC_RegLFSR_valid_Out   (valid3),
        .SC_RegLFSR_wrap_Out    (wrap3)
    );

    // Reference step: double the value modulo 256, add parity of tapped bits
    function automatic logic [7:0] m_step(input logic [7:0] v);
        int ones = 0;
        int nv;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && TAPS[i]) ones++;
        end
        nv = ((int'(v) * 2) % 256) + (ones % 2);
        return 8'(nv);
    endfunction

    function automatic logic [7:0] m_seed(input logic [7:0] s);
        return (s == 8'd0) ? 8'd1 : s;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seed = 8'h00; load = 1'b0; mode = 2'b00; req = 1'b0; ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (data1 !== 8'h01 || valid1 !== 1'b0 || wrap1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got data=%h valid=%b wrap=%b expected data=01 valid=0 wrap=0",
                         c, data1, valid1, wrap1);
            end
        end
        $display("reset_hold: done");
    endtask

    task automatic test_freerun();
        logic [7:0] tbl [7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        do_load(8'h01);
        mode = 2'b01; ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (valid1 !== 1'b1 || data1 !== tbl[k]) begin
                errors++;
                $display("FAIL freerun_word%0d: got valid=%b data=%h expected valid=1 data=%h",
                         k, valid1, data1, tbl[k]);
            end
            $display("freerun word %0d data=%h", k, data1);
        end
        mode = 2'b00;
        tick();
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL freerun_stop: got valid=%b expected 0", valid1);
        end
    endtask

    task automatic test_back_pressure();
        do_load(8'h01);
        mode = 2'b01; ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (data1 !== 8'h08 || valid1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_pre: got data=%h valid=%b expected data=08 valid=1", data1, valid1);
        end
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (data1 !== 8'h08 || valid1 !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got data=%h valid=%b expected data=08 valid=1",
                         c, data1, valid1);
            end
        end
        ready = 1'b1;
        tick();
        checks++;
        if (data1 !== 8'h11 || valid1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got data=%h expected 11", data1);
        end
        tick();
        checks++;
        if (data1 !== 8'h23) begin
            errors++;
            $display("FAIL bp_next: got data=%h expected 23", data1);
        end
        mode = 2'b00;
        tick();
        $display("back_pressure: done");
    endtask

    task automatic test_zero_wrap();
        logic wrap_exp;
        do_load(8'h00);
        checks++;
        if (data1 !== 8'h01 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed: got data=%h valid=%b expected data=01 valid=0", data1, valid1);
        end
        mode = 2'b01; ready = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            wrap_exp = (k == 255);
            checks++;
            if (wrap1 !== wrap_exp || valid1 !== 1'b1) begin
                errors++;
                $display("FAIL wrap_word%0d: got wrap=%b valid=%b data=%h expected wrap=%b valid=1",
                         k, wrap1, valid1, data1, wrap_exp);
            end
        end
        checks++;
        if (data1 !== 8'h01) begin
            errors++;
            $display("FAIL wrap_data: got %h expected 01", data1);
        end
        $display("zero_wrap: word255 data=%h wrap=%b", data1, wrap1);
        mode = 2'b00;
        tick();
    endtask

    task automatic test_ondemand();
        logic [7:0] exp_w;
        ready = 1'b0; mode = 2'b10; req = 1'b0;
        do_load(8'h01);
        req = 1'b1;
        tick();                       // req sampled in IDLE
        req = 1'b0;
        checks++;
        if (valid3 !== 1'b0) begin
            errors++;
            $display("FAIL od_edge1: got valid=%b expected 0", valid3);
        end
        req = 1'b1;                   // extra request during SHIFT
        tick();
        req = 1'b0;
        checks++;
        if (valid3 !== 1'b0) begin
            errors++;
            $display("FAIL od_edge2: got valid=%b expected 0", valid3);
        end
        tick();
        exp_w = m_step(m_step(m_step(8'h01)));
        checks++;
        if (valid3 !== 1'b1 || data3 !== exp_w) begin
            errors++;
            $display("FAIL od_present: got valid=%b data=%h expected valid=1 data=%h", valid3, data3, exp_w);
        end
        $display("ondemand word data=%h", data3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (valid3 !== 1'b0 || data3 !== exp_w) begin
                errors++;
                $display("FAIL od_idle cyc%0d: got valid=%b data=%h expected valid=0 data=%h",
                         c, valid3, data3, exp_w);
            end
            tick();
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick();
        exp_w = m_step(m_step(m_step(exp_w)));
        checks++;
        if (valid3 !== 1'b1 || data3 !== exp_w) begin
            errors++;
            $display("FAIL od_second: got valid=%b data=%h expected valid=1 data=%h", valid3, data3, exp_w);
        end
        ready = 1'b1; mode = 2'b00;
        tick();
    endtask

    task automatic test_mid_load();
        logic [7:0] exp_w;
        ready = 1'b1; mode = 2'b01;
        do_load(8'h01);
        tick();                       // dut3 now shifting
        seed = 8'h5A; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (valid3 !== 1'b0 || data3 !== 8'h5A) begin
            errors++;
            $display("FAIL midload: got valid=%b data=%h expected valid=0 data=5a", valid3, data3);
        end
        tick(); tick();
        checks++;
        if (valid3 !== 1'b0) begin
            errors++;
            $display("FAIL midload_shift: got valid=%b expected 0", valid3);
        end
        tick();
        exp_w = m_step(m_step(m_step(8'h5A)));
        checks++;
        if (valid3 !== 1'b1 || data3 !== exp_w) begin
            errors++;
            $display("FAIL midload_word: got valid=%b data=%h expected valid=1 data=%h", valid3, data3, exp_w);
        end
        $display("mid_load word data=%h", data3);
    endtask

    task automatic test_mid_reset();
        mode = 2'b01; ready = 1'b0;
        do_load(8'h37);
        tick();
        checks++;
        if (valid1 !== 1'b1 || data1 !== m_step(8'h37)) begin
            errors++;
            $display("FAIL midrst_pre: got valid=%b data=%h expected valid=1 data=%h",
                     valid1, data1, m_step(8'h37));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mode = 2'b00;
        checks++;
        if (valid1 !== 1'b0 || data1 !== 8'h01 || wrap1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst: got valid=%b data=%h wrap=%b expected valid=0 data=01 wrap=0",
                     valid1, data1, wrap1);
        end
    endtask

    // Random modes, requests and ready: presented words must be the
    // successive LFSR steps from the loaded seed, whatever the gaps.
    task automatic test_random();
        logic [7:0] ref_seed;
        logic [7:0] exp_w;
        logic       exp_wrap;
        int         words = 0;
        ref_seed = 8'($urandom_range(0, 255));
        do_load(ref_seed);
        ref_seed = m_seed(ref_seed);
        exp_w = m_step(ref_seed);
        for (int c = 0; c < 400; c++) begin
            if (valid1) begin
                exp_wrap = (exp_w == ref_seed);
                checks++;
                if (data1 !== exp_w || wrap1 !== exp_wrap) begin
                    errors++;
                    $display("FAIL random cyc%0d: got data=%h wrap=%b expected data=%h wrap=%b",
                             c, data1, wrap1, exp_w, exp_wrap);
                end
            end
            mode  = 2'($urandom_range(0, 3));
            req   = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            if (valid1 && ready) begin
                exp_w = m_step(exp_w);
                words++;
            end
            tick();
        end
        checks++;
        if (words < 20) begin
            errors++;
            $display("FAIL random_progress: got %0d words expected at least 20", words);
        end
        $display("random: %0d words accepted", words);
        mode = 2'b00; req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_back_pressure();
        test_zero_wrap();
        test_ondemand();
        test_mid_load();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
